sram_nr1w: RTL and testbench

//  Block SRAM with NUM_READ_PORTS synchronous read ports and one byte-enabled write port.

---
 rtl/sram_nr1w_pkg.sv | 35 +++
 rtl/sram_nr1w_if.sv | 27 ++
 rtl/sram_nr1w_clear_sequencer.sv | 57 +++++
 rtl/sram_nr1w.sv | 128 ++++++++++++
 tb/tb_sram_nr1w.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_nr1w_pkg.sv
// Shared types and helpers for the sram_nr1w block family.
package sram_nr1w_pkg;

  typedef enum logic [1:0] {
    RDW_NEW_DATA  = 2'd0,
    RDW_OLD_DATA  = 2'd1,
    RDW_DONT_CARE = 2'd2
  } rdw_mode_t;

  typedef enum logic [0:0] {
    CLR_ST_CLEAR = 1'b0,
    CLR_ST_READY = 1'b1
  } clr_state_t;

  // Policy names are passed as string parameters and compared as packed bytes.
  localparam int RDW_STR_W = 72;

  function automatic logic rdw_str_valid(input logic [RDW_STR_W-1:0] s);
    return (s == RDW_STR_W'("NEW_DATA")) || (s == RDW_STR_W'("OLD_DATA")) ||
           (s == RDW_STR_W'("DONT_CARE"));
  endfunction

  function automatic rdw_mode_t rdw_from_str(input logic [RDW_STR_W-1:0] s);
    rdw_mode_t m;
    if (s == RDW_STR_W'("OLD_DATA")) begin
      m = RDW_OLD_DATA;
    end else if (s == RDW_STR_W'("DONT_CARE")) begin
      m = RDW_DONT_CARE;
    end else begin
      m = RDW_NEW_DATA;
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_nr1w_if.sv
// Read/write port bundle for sram_nr1w; the array owner uses the slave modport.
interface sram_nr1w_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int NUM_READ_PORTS = 2
);
  localparam int ADDR_WIDTH = $clog2(SIZE);

  logic                                           init_done;
  logic [NUM_READ_PORTS-1:0]                      read_en;
  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]      read_addr;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]      read_data;
  logic                                           write_en;
  logic [ADDR_WIDTH-1:0]                          write_addr;
  logic [DATA_WIDTH/8-1:0]                        write_byte_en;
  logic [DATA_WIDTH-1:0]                          write_data;

  modport master (
    input  init_done, read_data,
    output read_en, read_addr, write_en, write_addr, write_byte_en, write_data
  );

  modport slave (
    output init_done, read_data,
    input  read_en, read_addr, write_en, write_addr, write_byte_en, write_data
  );
endinterface

// File: rtl/sram_nr1w_clear_sequencer.sv
// Post-reset fill sequencer: walks every word once, then reports the array usable.
module sram_nr1w_clear_sequencer import sram_nr1w_pkg::*; #(
  parameter int SIZE           = 1024,
  parameter int ADDR_WIDTH     = $clog2(SIZE),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  init_done
);
  localparam clr_state_t            RESET_STATE = CLEAR_ON_RESET ? CLR_ST_CLEAR : CLR_ST_READY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(SIZE - 1);

  clr_state_t            state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
  logic                  clear_we_s;
  logic                  init_done_r;

  // State, fill address and usable flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RESET_STATE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      addr_r      <= addr_next_s;
      init_done_r <= (state_next_s == CLR_ST_READY);
    end
  end

  // Next-state and fill-strobe decode.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = addr_r;
    clear_we_s   = 1'b0;
    case (state_r)
      CLR_ST_CLEAR: begin
        clear_we_s = 1'b1;
        if (addr_r == LAST_ADDR) begin
          state_next_s = CLR_ST_READY;
          addr_next_s  = {ADDR_WIDTH{1'b0}};
        end else begin
          addr_next_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      CLR_ST_READY: state_next_s = CLR_ST_READY;
      default:      state_next_s = RESET_STATE;
    endcase
  end

  assign clear_we   = clear_we_s;
  assign clear_addr = addr_r;
  assign init_done  = init_done_r;
endmodule

// File: rtl/sram_nr1w.sv
// Multi-read, single byte-enabled write SRAM with built-in post-reset fill and
// per-port read-during-write handling.
module sram_nr1w import sram_nr1w_pkg::*; #(
  parameter int                    DATA_WIDTH        = 32,
  parameter int                    SIZE              = 1024,
  parameter int                    NUM_READ_PORTS    = 2,
  parameter                        READ_DURING_WRITE = "NEW_DATA",
  parameter bit                    OUTPUT_REG        = 1'b0,
  parameter bit                    CLEAR_ON_RESET    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE       = {DATA_WIDTH{1'b0}},
  parameter int                    ADDR_WIDTH        = $clog2(SIZE)
) (
  input  logic        clk,
  input  logic        reset,
  sram_nr1w_if.slave  bus
);
  localparam int                  NBYTES   = DATA_WIDTH / 8;
  localparam rdw_mode_t           RDW_MODE = rdw_from_str(RDW_STR_W'(READ_DURING_WRITE));
  localparam logic [ADDR_WIDTH:0] SIZE_X   = (ADDR_WIDTH + 1)'(SIZE);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("sram_nr1w: DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_READ_PORTS < 1) begin : g_bad_ports
    $error("sram_nr1w: NUM_READ_PORTS must be at least 1");
  end
  if (!rdw_str_valid(RDW_STR_W'(READ_DURING_WRITE))) begin : g_bad_rdw
    $error("sram_nr1w: unknown READ_DURING_WRITE policy");
  end

  function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [NBYTES-1:0]     be);
    logic [DATA_WIDTH-1:0] w;
    w = old_w;
    for (int b = 0; b < NBYTES; b++) begin
      if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    end
    return w;
  endfunction

  logic [DATA_WIDTH-1:0]                     mem_r [SIZE];
  logic                                      clear_we_s;
  logic [ADDR_WIDTH-1:0]                     clear_addr_s;
  logic                                      init_done_s;
  logic                                      ext_we_s;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_out_s;

  sram_nr1w_clear_sequencer #(
    .SIZE           (SIZE),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .clear_we   (clear_we_s),
    .clear_addr (clear_addr_s),
    .init_done  (init_done_s)
  );

  // Out-of-range writes are dropped here so they can never alias a real word.
  assign ext_we_s = init_done_s && bus.write_en && ({1'b0, bus.write_addr} < SIZE_X);

  // Array write port; the fill sequencer wins over the external port.
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem_r[clear_addr_s] <= CLEAR_VALUE;
    end else if (ext_we_s) begin
      mem_r[bus.write_addr] <= merge_word(mem_r[bus.write_addr], bus.write_data, bus.write_byte_en);
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] old_s, rd_next_s, rd1_r;
    logic                  addr_ok_s, hit_s;

    // Stage-1 source word including same-address write resolution.
    always_comb begin
      addr_ok_s = ({1'b0, bus.read_addr[p]} < SIZE_X);
      hit_s     = ext_we_s && (bus.write_addr == bus.read_addr[p]);
      old_s     = {DATA_WIDTH{1'b0}};
      rd_next_s = {DATA_WIDTH{1'b0}};
      if (addr_ok_s) begin
        old_s = mem_r[bus.read_addr[p]];
      end else begin
        old_s = {DATA_WIDTH{1'b0}};
      end
      if (hit_s) begin
        case (RDW_MODE)
          RDW_NEW_DATA:  rd_next_s = merge_word(old_s, bus.write_data, bus.write_byte_en);
          RDW_OLD_DATA:  rd_next_s = old_s;
          RDW_DONT_CARE: rd_next_s = {DATA_WIDTH{1'bx}};
          default:       rd_next_s = old_s;
        endcase
      end else begin
        rd_next_s = old_s;
      end
    end

    // Stage-1 register: holds unless this port reads while the array is usable.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd1_r <= {DATA_WIDTH{1'b0}};
      end else if (init_done_s && bus.read_en[p]) begin
        rd1_r <= rd_next_s;
      end
    end

    if (OUTPUT_REG) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd2_r;

      // Stage-2 register: unconditional copy of stage 1.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd2_r <= {DATA_WIDTH{1'b0}};
        end else begin
          rd2_r <= rd1_r;
        end
      end
      assign rd_out_s[p] = rd2_r;
    end else begin : g_noreg
      assign rd_out_s[p] = rd1_r;
    end
  end

  assign bus.read_data = rd_out_s;
  assign bus.init_done = init_done_s;
endmodule

// File: tb/tb_sram_nr1w.sv
// Directed bench for sram_nr1w: three configurations driven in lockstep, scoreboard
// of expected read words plus explicit checks of the headline scenarios.
module tb_sram_nr1w;
  localparam int NP = 2;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]      ren;
  logic [NP-1:0][3:0] raddr;
  logic               we;
  logic [3:0]         waddr;
  logic [3:0]         wbe;
  logic [31:0]        wdata;

  sram_nr1w_if #(.DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(NP)) ifa ();
  sram_nr1w_if #(.DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(NP)) ifb ();
  sram_nr1w_if #(.DATA_WIDTH(32), .SIZE(12), .NUM_READ_PORTS(NP)) ifc ();

  assign ifa.read_en = ren;  assign ifa.read_addr = raddr;  assign ifa.write_en = we;
  assign ifa.write_addr = waddr;  assign ifa.write_byte_en = wbe;  assign ifa.write_data = wdata;
  assign ifb.read_en = ren;  assign ifb.read_addr = raddr;  assign ifb.write_en = we;
  assign ifb.write_addr = waddr;  assign ifb.write_byte_en = wbe;  assign ifb.write_data = wdata;
  assign ifc.read_en = ren;  assign ifc.read_addr = raddr;  assign ifc.write_en = we;
  assign ifc.write_addr = waddr;  assign ifc.write_byte_en = wbe;  assign ifc.write_data = wdata;

  sram_nr1w #(.DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(NP), .READ_DURING_WRITE("NEW_DATA"),
              .OUTPUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'hA5A5A5A5))
    u_a (.clk(clk), .reset(reset), .bus(ifa));
  sram_nr1w #(.DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(NP), .READ_DURING_WRITE("OLD_DATA"),
              .OUTPUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h00000000))
    u_b (.clk(clk), .reset(reset), .bus(ifb));
  sram_nr1w #(.DATA_WIDTH(32), .SIZE(12), .NUM_READ_PORTS(NP), .READ_DURING_WRITE("NEW_DATA"),
              .OUTPUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h00000000))
    u_c (.clk(clk), .reset(reset), .bus(ifc));

  int          cfg_size [ND] = '{16, 16, 12};
  int          cfg_oreg [ND] = '{0, 1, 0};
  bit          cfg_old  [ND] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] cfg_clr  [ND] = '{32'hA5A5A5A5, 32'h00000000, 32'h00000000};

  logic [31:0] mdl_mem [ND][16];
  int          clr_cnt [ND];
  bit          mdl_done [ND];
  logic [31:0] exp1 [ND][NP];

  typedef struct {
    int          d;
    int          p;
    logic [31:0] v;
    int          due;
  } exp_t;
  exp_t sbq[$];

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = o;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = n[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] get_rd(input int d, input int p);
    case (d)
      0:       return ifa.read_data[p];
      1:       return ifb.read_data[p];
      default: return ifc.read_data[p];
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return ifa.init_done;
      1:       return ifb.init_done;
      default: return ifc.init_done;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    ren = '0; raddr = '0; we = 1'b0; waddr = 4'd0; wbe = 4'd0; wdata = 32'd0;
  endtask

  // One clock: update the model, queue expected words, advance, then score.
  task automatic step();
    logic [31:0] v;
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        clr_cnt[d] = 0;
        mdl_done[d] = 1'b0;
        for (int p = 0; p < NP; p++) exp1[d][p] = 32'd0;
      end else if (mdl_done[d]) begin
        for (int p = 0; p < NP; p++) begin
          if (ren[p]) begin
            if (int'(raddr[p]) >= cfg_size[d]) begin
              v = 32'd0;
            end else begin
              v = mdl_mem[d][raddr[p]];
              if (we && waddr == raddr[p] && !cfg_old[d]) v = merge(v, wdata, wbe);
            end
            exp1[d][p] = v;
          end
        end
        if (we && int'(waddr) < cfg_size[d]) mdl_mem[d][waddr] = merge(mdl_mem[d][waddr], wdata, wbe);
      end else begin
        clr_cnt[d]++;
        if (clr_cnt[d] == cfg_size[d]) begin
          for (int a = 0; a < cfg_size[d]; a++) mdl_mem[d][a] = cfg_clr[d];
          mdl_done[d] = 1'b1;
        end
      end
    end
    if (reset) sbq.delete();
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NP; p++) begin
        sbq.push_back('{d, p, exp1[d][p], cyc + 1 + cfg_oreg[d]});
        if (reset && cfg_oreg[d] != 0) sbq.push_back('{d, p, 32'd0, cyc + 1});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < ND; d++)
      check($sformatf("init_done d%0d cyc%0d", d, cyc), {31'd0, get_done(d)}, {31'd0, mdl_done[d]});
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        check($sformatf("rd d%0d p%0d cyc%0d", sbq[i].d, sbq[i].p, cyc),
              get_rd(sbq[i].d, sbq[i].p), sbq[i].v);
        sbq.delete(i);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      clr_cnt[d] = 0;
      mdl_done[d] = 1'b0;
      for (int a = 0; a < 16; a++) mdl_mem[d][a] = 32'd0;
      for (int p = 0; p < NP; p++) exp1[d][p] = 32'd0;
    end
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // First clear, interrupted at cycle 7; external traffic must be ignored.
    for (int i = 0; i < 7; i++) begin
      we = 1'b1; waddr = 4'd1; wbe = 4'hF; wdata = 32'hFFFFFFFF;
      ren = 2'b11; raddr[0] = 4'd2; raddr[1] = 4'd3;
      step();
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 5) begin
        we = 1'b1; waddr = 4'd4; wbe = 4'hF; wdata = 32'h5A5A5A5A; ren = 2'b11;
      end else begin
        idle();
      end
      step();
    end
    check("a init_done after 16", {31'd0, ifa.init_done}, 32'd1);

    // Sweep: every address returns the fill word.
    for (int i = 0; i < 16; i++) begin
      ren = 2'b11; raddr[0] = 4'(i); raddr[1] = 4'(15 - i);
      step();
      if (i < 16) check("a sweep p0", ifa.read_data[0], 32'hA5A5A5A5);
    end
    idle(); step();

    // Byte-enabled merge.
    we = 1'b1; waddr = 4'd3; wbe = 4'hF; wdata = 32'h11223344; step();
    wbe = 4'b0101; wdata = 32'hAABBCCDD; step();
    idle(); ren = 2'b11; raddr[0] = 4'd3; raddr[1] = 4'd3; step();
    check("a merge p0", ifa.read_data[0], 32'h11BB33DD);
    check("c merge p1", ifc.read_data[1], 32'h11BB33DD);
    check("b merge early", ifb.read_data[0], 32'h00000000);
    idle(); step();
    check("b merge late", ifb.read_data[0], 32'h11BB33DD);

    // Same-address read during write.
    we = 1'b1; waddr = 4'd5; wbe = 4'hF; wdata = 32'hDEADBEEF;
    ren = 2'b11; raddr[0] = 4'd5; raddr[1] = 4'd5; step();
    check("a rdw new p0", ifa.read_data[0], 32'hDEADBEEF);
    check("a rdw new p1", ifa.read_data[1], 32'hDEADBEEF);
    idle(); ren = 2'b11; raddr[0] = 4'd5; raddr[1] = 4'd5; step();
    check("b rdw old p0", ifb.read_data[0], 32'h00000000);
    check("b rdw old p1", ifb.read_data[1], 32'h00000000);
    idle(); step();
    check("b after write", ifb.read_data[1], 32'hDEADBEEF);

    // Port 1 holds while port 0 keeps reading.
    we = 1'b1; waddr = 4'd7; wbe = 4'hF; wdata = 32'h00000077; step();
    idle(); ren = 2'b10; raddr[1] = 4'd7; step();
    idle(); ren = 2'b01; raddr[0] = 4'd3; step();
    check("a hold p1", ifa.read_data[1], 32'h00000077);
    check("a upd p0", ifa.read_data[0], 32'h11BB33DD);
    idle(); ren = 2'b01; raddr[0] = 4'd5; step();
    check("a hold2 p1", ifa.read_data[1], 32'h00000077);
    check("a upd2 p0", ifa.read_data[0], 32'hDEADBEEF);

    // Out-of-range on the 12-word instance: no write, zero read, no aliasing.
    we = 1'b1; waddr = 4'd1; wbe = 4'hF; wdata = 32'h00000055; step();
    waddr = 4'd13; wdata = 32'h12345678; step();
    idle(); ren = 2'b11; raddr[0] = 4'd13; raddr[1] = 4'd1; step();
    check("c oor read", ifc.read_data[0], 32'h00000000);
    check("c no alias", ifc.read_data[1], 32'h00000055);
    check("a addr13", ifa.read_data[0], 32'h12345678);

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); waddr = 4'($urandom); wbe = 4'($urandom);
      wdata = $urandom; ren = 2'($urandom); raddr[0] = 4'($urandom); raddr[1] = 4'($urandom);
      step();
    end
    idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
